// File: rtl/load_store_unit.sv
// RV32I load/store unit: sizes, lane-steers and extends core requests onto a word bus.
// Latency: accept in cycle 0, response in cycle 3 at best; bus_ready stalls hold ADDR; missing bus_rvalid times out.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests error out instead of being silently aligned.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;

    logic        req_ready_d, resp_valid_d, resp_error_d, bus_valid_d, bus_write_d;
    logic [31:0] resp_rdata_d, bus_addr_d, bus_wdata_d;
    logic [3:0]  bus_wstrb_d;

    logic        legal, misalign, trap;
    logic [31:0] eff_addr, load_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Request decode and address alignment
    always_comb begin
        misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (req_write)
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        else
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = misalign;
`else
        trap = 1'b0;
`endif
        eff_addr = req_addr;
        if (req_funct3[1:0] == 2'b01)
            eff_addr[0] = 1'b0;
        else if (req_funct3[1:0] == 2'b10)
            eff_addr[1:0] = 2'b00;
    end

    // Lane select and extension of the returned word
    always_comb begin
        ld_byte = bus_rdata[8*lane_q +: 8];
        ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_ext = {24'd0, ld_byte};
            3'b101:  load_ext = {16'd0, ld_half};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        bus_write_d  = bus_write;
        bus_addr_d   = bus_addr;
        bus_wdata_d  = bus_wdata;
        bus_wstrb_d  = bus_wstrb;
        resp_error_d = 1'b0;
        resp_rdata_d = 32'd0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    lane_d   = eff_addr[1:0];
                    if (!legal || trap) begin
                        state_d      = RESP;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d     = ADDR;
                        bus_write_d = req_write;
                        bus_addr_d  = {eff_addr[31:2], 2'b00};
                        case (req_funct3[1:0])
                            2'b00: begin
                                bus_wdata_d = {4{req_wdata[7:0]}};
                                bus_wstrb_d = 4'b0001 << eff_addr[1:0];
                            end
                            2'b01: begin
                                bus_wdata_d = {2{req_wdata[15:0]}};
                                bus_wstrb_d = 4'b0011 << {eff_addr[1], 1'b0};
                            end
                            default: begin
                                bus_wdata_d = req_wdata;
                                bus_wstrb_d = 4'b1111;
                            end
                        endcase
                        if (!req_write)
                            bus_wstrb_d = 4'b0000;
                    end
                end
            end
            ADDR: begin
                if (bus_ready) begin
                    state_d = DATA;
                    cnt_d   = 8'd0;
                end
            end
            DATA: begin
                if (bus_rvalid) begin
                    state_d      = RESP;
                    resp_rdata_d = write_q ? 32'd0 : load_ext;
                end else if (cnt_q == TO_LAST) begin
                    state_d      = RESP;
                    resp_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Control outputs are registered copies of the next-state decode
        req_ready_d  = (state_d == IDLE);
        bus_valid_d  = (state_d == ADDR);
        resp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            write_q    <= 1'b0;
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            bus_valid  <= 1'b0;
            bus_write  <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            bus_wstrb  <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            funct3_q   <= funct3_d;
            lane_q     <= lane_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_error <= resp_error_d;
            bus_valid  <= bus_valid_d;
            bus_write  <= bus_write_d;
            bus_addr   <= bus_addr_d;
            bus_wdata  <= bus_wdata_d;
            bus_wstrb  <= bus_wstrb_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lane steering, extension, stalls, timeout, reset abort.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        bus_valid, bus_ready, bus_write, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int n_checks = 0;
    int n_fails  = 0;

    // Per-transaction observations
    int          lat, bus_cycles, ready_delay;
    logic        rvalid_en, addr_stable;
    logic        a_write;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_wstrb;
    logic [31:0] r_rdata;
    logic        r_err, post_ready, post_rv;

    load_store_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request and play the bus side until the response pulse (bounded)
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        int wait_n;
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        tick;
        req_valid   = 1'b0;
        lat         = 1;
        bus_cycles  = 0;
        addr_stable = 1'b1;
        a_write     = bus_write;
        a_addr      = bus_addr;
        a_wdata     = bus_wdata;
        a_wstrb     = bus_wstrb;
        wait_n      = 0;
        while (!resp_valid && lat < 100) begin
            if (bus_valid) begin
                bus_cycles++;
                if (bus_addr !== a_addr) addr_stable = 1'b0;
                bus_ready = (wait_n >= ready_delay);
                wait_n++;
            end else begin
                bus_ready = 1'b0;
            end
            bus_rvalid = rvalid_en;
            tick;
            lat++;
        end
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        r_rdata    = resp_rdata;
        r_err      = resp_error;
        tick;
        post_ready = req_ready;
        post_rv    = resp_valid;
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_funct3  = 3'd0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        bus_ready   = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = 32'd0;
        ready_delay = 0;
        rvalid_en   = 1'b1;

        // Reset state
        tick;
        tick;
        chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_bus_valid",  {31'd0, bus_valid},  32'd0);
        chk("rst_outputs",    resp_rdata | bus_addr | bus_wdata | {28'd0, bus_wstrb}, 32'd0);
        reset = 1'b0;
        tick;
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);

        // LB signed, top lane
        bus_rdata = 32'h80FF_1234;
        do_req(1'b0, 3'b000, 32'h13, 32'd0);
        chk("lb_bus_addr",   a_addr, 32'h10);
        chk("lb_bus_wstrb",  {28'd0, a_wstrb}, 32'd0);
        chk("lb_bus_write",  {31'd0, a_write}, 32'd0);
        chk("lb_latency",    lat, 3);
        chk("lb_rdata",      r_rdata, 32'hFFFF_FF80);
        chk("lb_err",        {31'd0, r_err}, 32'd0);
        chk("lb_idle_ready", {31'd0, post_ready}, 32'd1);
        chk("lb_pulse_once", {31'd0, post_rv}, 32'd0);

        // SH to upper half
        bus_rdata = 32'h1234_5678;
        do_req(1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
        chk("sh_bus_addr",  a_addr, 32'h20);
        chk("sh_bus_wstrb", {28'd0, a_wstrb}, 32'hC);
        chk("sh_bus_wdata", a_wdata, 32'hBEEF_BEEF);
        chk("sh_bus_write", {31'd0, a_write}, 32'd1);
        chk("sh_rdata",     r_rdata, 32'd0);
        chk("sh_latency",   lat, 3);

        // SB lane 1
        do_req(1'b1, 3'b000, 32'h01, 32'h1234_56A5);
        chk("sb_bus_wstrb", {28'd0, a_wstrb}, 32'h2);
        chk("sb_bus_wdata", a_wdata, 32'hA5A5_A5A5);

        // SW full word
        do_req(1'b1, 3'b010, 32'h48, 32'hCAFE_F00D);
        chk("sw_bus_wstrb", {28'd0, a_wstrb}, 32'hF);
        chk("sw_bus_wdata", a_wdata, 32'hCAFE_F00D);

        // Half / unsigned byte loads
        bus_rdata = 32'h80FF_1234;
        do_req(1'b0, 3'b101, 32'h12, 32'd0);
        chk("lhu_rdata", r_rdata, 32'h0000_80FF);
        do_req(1'b0, 3'b001, 32'h12, 32'd0);
        chk("lh_rdata",  r_rdata, 32'hFFFF_80FF);
        do_req(1'b0, 3'b001, 32'h10, 32'd0);
        chk("lh_lo_rdata", r_rdata, 32'h0000_1234);
        do_req(1'b0, 3'b100, 32'h13, 32'd0);
        chk("lbu_rdata", r_rdata, 32'h0000_0080);

        // LW with three stall cycles on bus_ready
        bus_rdata   = 32'hDEAD_BEEF;
        ready_delay = 3;
        do_req(1'b0, 3'b010, 32'h100, 32'd0);
        chk("lw_stall_bus_cycles", bus_cycles, 4);
        chk("lw_stall_addr_stable", {31'd0, addr_stable}, 32'd1);
        chk("lw_stall_latency", lat, 6);
        chk("lw_stall_rdata", r_rdata, 32'hDEAD_BEEF);
        ready_delay = 0;

        // LHU with no read response: timeout
        rvalid_en = 1'b0;
        do_req(1'b0, 3'b101, 32'h40, 32'd0);
        chk("to_latency", lat, 17);
        chk("to_err",     {31'd0, r_err}, 32'd1);
        chk("to_rdata",   r_rdata, 32'd0);
        chk("to_idle",    {31'd0, post_ready}, 32'd1);
        rvalid_en = 1'b1;

        // Misaligned LW
        bus_rdata = 32'h0BAD_F00D;
        do_req(1'b0, 3'b010, 32'h06, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_err",        {31'd0, r_err}, 32'd1);
        chk("mis_bus_cycles", bus_cycles, 0);
        chk("mis_latency",    lat, 1);
`else
        chk("mis_bus_addr", a_addr, 32'h04);
        chk("mis_err",      {31'd0, r_err}, 32'd0);
        chk("mis_rdata",    r_rdata, 32'h0BAD_F00D);
        chk("mis_latency",  lat, 3);
`endif

        // Illegal store size
        do_req(1'b1, 3'b100, 32'h08, 32'h55);
        chk("ill_st_err",        {31'd0, r_err}, 32'd1);
        chk("ill_st_bus_cycles", bus_cycles, 0);
        chk("ill_st_latency",    lat, 1);

        // Reset while in DATA
        rvalid_en  = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h40;
        tick;
        req_valid = 1'b0;
        chk("ab_in_addr", {31'd0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("ab_bus_valid",  {31'd0, bus_valid},  32'd0);
        chk("ab_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("ab_req_ready",  {31'd0, req_ready},  32'd0);
        tick;
        reset      = 1'b0;
        bus_rvalid = 1'b1;
        tick;
        chk("ab_rel_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ab_no_resp", {31'd0, resp_valid}, 32'd0);
            tick;
        end
        bus_rvalid = 1'b0;
        rvalid_en  = 1'b1;

        // Reserved load size after reset
        do_req(1'b0, 3'b011, 32'h00, 32'd0);
        chk("ill_ld_err",        {31'd0, r_err}, 32'd1);
        chk("ill_ld_bus_cycles", bus_cycles, 0);
        chk("ill_ld_rdata",      r_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 15, DATA-state cycles without bus_rvalid before error (legal range 1..255).
REQ-002 SHALL have ports, one per line, as follows.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  core load/store request.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, in low-order bits.
- req_ready  out  1  request accepted when high with req_valid.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data.
- resp_error  out  1  error qualifier on resp_valid.
- bus_valid  out  1  bus command valid.
- bus_ready  in  1  bus command accepted.
- bus_write  out  1  bus command is a write.
- bus_addr  out  32  word-aligned address, bits [1:0] = 0.
- bus_wdata  out  32  lane-replicated write data.
- bus_wstrb  out  4  byte strobes; 0 on reads.
- bus_rvalid  in  1  read data or write acknowledge.
- bus_rdata  in  32  read word.

Function
REQ-003 SHALL implement FSM states: IDLE, ADDR, DATA, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready, and all request fields are captured on acceptance.
REQ-005 A legal request SHALL go IDLE->ADDR; bus_valid SHALL be 1 throughout ADDR, with bus_addr, bus_write, bus_wdata and bus_wstrb held stable until bus_ready.
REQ-006 In ADDR with bus_ready=1, the FSM SHALL go to DATA; bus_rvalid in ADDR SHALL be ignored.
REQ-007 In DATA, bus_rvalid=1 SHALL capture data and go to RESP; minimum latency SHALL be acceptance in cycle 0 and resp_valid in cycle 3.
REQ-008 A timeout counter SHALL clear on DATA entry and increment each DATA cycle without bus_rvalid; when it reaches TIMEOUT_CYCLES, the FSM SHALL go to RESP with resp_error=1 and resp_rdata=0.
REQ-009 In RESP, resp_valid SHALL be 1 for exactly one cycle, then go to IDLE; a new request SHALL NOT be accepted in RESP.
REQ-010 funct3 decode SHALL be: 000 byte signed; 001 half signed; 010 word; 100 byte unsigned; 101 half unsigned.
REQ-011 Stores SHALL use funct3 000, 001 or 010 only; other store codes are illegal.
REQ-012 Any illegal funct3 SHALL go IDLE->RESP with resp_error=1, with no bus transaction.
REQ-013 Store strobes SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Byte data SHALL be replicated to all 4 lanes and half data to both halves.
REQ-014 Loads SHALL select the lane by addr[1:0], then sign- or zero-extend it to 32 bits per funct3.
REQ-015 Store responses SHALL return resp_rdata=0; bus_rvalid acts as the write acknowledge.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 Asserting reset SHALL immediately force IDLE and clear the timeout counter.
REQ-018 While reset is asserted, all outputs SHALL be 0 except req_ready, which SHALL be 0 during reset and 1 in the first cycle after release.
REQ-019 Reset mid-transaction SHALL drop bus_valid immediately and discard the transaction with no response.

Configuration
REQ-020 With LSU_MISALIGN_TRAP_EN defined, a misaligned request SHALL go IDLE->RESP with resp_error=1 and no bus transaction.
REQ-021 Misaligned SHALL mean: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-022 Without LSU_MISALIGN_TRAP_EN, misaligned requests SHALL have addr[0] cleared (half) or addr[1:0] cleared (word) and proceed normally, with no error.

Verification
REQ-023 LB, addr=0x13, bus_rdata=0x80FF_1234, immediate ready/rvalid -> bus_addr=0x10; resp_rdata=0xFFFF_FF80; resp_valid in cycle 3.
REQ-024 SH, addr=0x22, wdata=0x0000_BEEF -> bus_wstrb=4'b1100; bus_wdata=0xBEEF_BEEF; bus_write=1; resp_rdata=0.
REQ-025 LW with bus_ready low for 3 cycles -> bus_valid and bus_addr held stable for 4 cycles; resp_valid occurs 3 cycles later than the zero-wait case.
REQ-026 LHU, no bus_rvalid -> resp_error=1 exactly TIMEOUT_CYCLES (15) cycles after DATA entry; FSM returns to IDLE.
REQ-027 LW, addr=0x06 -> with the macro: resp_error=1, bus_valid never asserted. Without the macro: bus_addr=0x04 and normal response.
REQ-028 Reset asserted in DATA -> bus_valid=0 and resp_valid=0 at once; req_ready=1 in the first cycle after release; funct3=011 load -> error response with no bus activity.
